// File: rtl/handshake_arbiter_pkg.sv
// handshake_arbiter_pkg
// Shared definitions for the handshake arbiter: FSM state encoding,
// default parameter values and a small index helper.
// No ports (package).
package handshake_arbiter_pkg;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arbState_t;

  // Next requester index after idx, wrapping from count-1 back to 0.
  function automatic int wrapIncrement(input int idx, input int count);
    return (idx + 1 >= count) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/handshake_arbiter_if.sv
// handshake_arbiter_if
// Bundles the requester-facing handshake and the shared bus outputs.
// Signals:
//   req           per-requester level request
//   wr_data       per-requester data, slice i = [i*DATA_W +: DATA_W]
//   gnt           one-hot grant
//   sharedBus     registered data of the current owner
//   bus_valid     sharedBus carries owner data this cycle
//   owner         index of the granted requester, 0 when idle
//   busy          arbiter is in GRANT or RELEASE
//   timeout_pulse one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
interface handshake_arbiter_if
  import handshake_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
);

  localparam int OWNER_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wr_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         sharedBus;
  logic                      bus_valid;
  logic [OWNER_W-1:0]        owner;
  logic                      busy;
  logic                      timeout_pulse;

  modport master (
    output req, wr_data,
    input  gnt, sharedBus, bus_valid, owner, busy, timeout_pulse
  );

  modport slave (
    input  req, wr_data,
    output gnt, sharedBus, bus_valid, owner, busy, timeout_pulse
  );

endinterface

// File: rtl/handshake_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin search: returns the first set bit of
// 'pending' at or after 'start', wrapping past NUM_REQ-1 to 0.
// Ports:
//   pending  candidate vector
//   start    index where the search begins
//   winner   selected index (0 when nothing found)
//   found    at least one pending bit was set
module rr_picker
  import handshake_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         pending,
  input  logic [$clog2(NUM_REQ)-1:0] start,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       found
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int idx;

  // Walk offsets from farthest to nearest so the candidate closest to
  // 'start' is the last one written and therefore wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(start) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (pending[IDX_W'(idx)]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_arbiter.sv
// handshake_arbiter
// Round-robin arbiter granting one requester at a time to a shared
// registered data bus. A grant lasts while the owner keeps its request
// up, followed by a single RELEASE cycle before the next arbitration.
// Ports:
//   clkA   single clock, rising edge
//   reset  synchronous, active-high
//   arbIf  handshake_arbiter_if.slave (req/wr_data in, grant and bus out)
// Optional feature: define ARB_TIMEOUT_EN to bound each grant to MAX_HOLD
// cycles; a requester released that way is masked until it drops req.
module handshake_arbiter
  import handshake_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clkA,
  input  logic               reset,
  handshake_arbiter_if.slave arbIf
);

  localparam int OWNER_W = $clog2(NUM_REQ);

  arbState_t          state, stateNext;
  logic [OWNER_W-1:0] ownerReg, rrPtr, winner;
  logic               found;
  logic [NUM_REQ-1:0] pending, gntReg;
  logic [DATA_W-1:0]  busReg;
  logic               busValidReg;
  logic               doGrant, doStream, ownerReq;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]  holdCnt;
  logic [NUM_REQ-1:0] maskReg;
  logic               timeoutReg, doTimeout, holdExpired;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) picker (
    .pending(pending),
    .start  (rrPtr),
    .winner (winner),
    .found  (found)
  );

  assign ownerReq = arbIf.req[ownerReg];

  // State register.
  always_ff @(posedge clkA) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state plus the one-cycle action strobes for the datapath.
  // GRANT only looks at the owner's request; everyone else waits.
  always_comb begin
    stateNext = state;
    doGrant   = 1'b0;
    doStream  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    doTimeout = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          stateNext = GRANT;
          doGrant   = 1'b1;
        end
      end
      GRANT: begin
        if (!ownerReq) begin
          stateNext = RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (holdExpired) begin
          stateNext = RELEASE;
          doTimeout = 1'b1;
        end
`endif
        else begin
          doStream = 1'b1;
        end
      end
      RELEASE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Grant, owner, round-robin pointer and the shared bus registers.
  // The pointer is loaded at grant time with owner+1 so the next search
  // starts just past the requester that was served.
  always_ff @(posedge clkA) begin
    if (reset) begin
      gntReg      <= '0;
      busReg      <= '0;
      busValidReg <= 1'b0;
      ownerReg    <= '0;
      rrPtr       <= '0;
    end else begin
      busValidReg <= doStream;
      if (doStream) busReg <= arbIf.wr_data[ownerReg*DATA_W +: DATA_W];
      if (doGrant) begin
        gntReg   <= NUM_REQ'(1) << winner;
        ownerReg <= winner;
        rrPtr    <= OWNER_W'(wrapIncrement(int'(winner), NUM_REQ));
      end else if (state == GRANT && stateNext == RELEASE) begin
        gntReg <= '0;
      end else if (state == RELEASE) begin
        ownerReg <= '0;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign holdExpired = (holdCnt == HOLD_W'(MAX_HOLD - 1));
  assign pending     = arbIf.req & ~maskReg;

  // Hold counter and the mask of requesters that overstayed. A mask bit
  // survives until that requester is seen with req low.
  always_ff @(posedge clkA) begin
    if (reset) begin
      holdCnt    <= '0;
      maskReg    <= '0;
      timeoutReg <= 1'b0;
    end else begin
      timeoutReg <= doTimeout;
      if (doGrant)       holdCnt <= '0;
      else if (doStream) holdCnt <= holdCnt + HOLD_W'(1);
      maskReg <= (maskReg & arbIf.req) |
                 (doTimeout ? (NUM_REQ'(1) << ownerReg) : '0);
    end
  end

  assign arbIf.timeout_pulse = timeoutReg;
`else
  assign pending             = arbIf.req;
  assign arbIf.timeout_pulse = 1'b0;
`endif

  assign arbIf.gnt       = gntReg;
  assign arbIf.sharedBus = busReg;
  assign arbIf.bus_valid = busValidReg;
  assign arbIf.owner     = ownerReg;
  assign arbIf.busy      = (state != IDLE);

endmodule

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 Parameter DATA_W, default 64, shared bus data width.
REQ-003 Parameter MAX_HOLD, default 16, maximum grant length in cycles (only used with ARB_TIMEOUT_EN).
REQ-004 Port clkA  input  1  single clock; all logic on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port req  input  NUM_REQ  per-requester request, level, held until done.
REQ-007 Port wr_data  input  NUM_REQ*DATA_W  per-requester data; slice i = bits [i*DATA_W +: DATA_W].
REQ-008 Port gnt  output  NUM_REQ  one-hot grant (at most one bit set), registered.
REQ-009 Port sharedBus  output  DATA_W  registered data of current owner.
REQ-010 Port bus_valid  output  1  sharedBus carries owner data this cycle.
REQ-011 Port owner  output  $clog2(NUM_REQ)  index of granted requester; 0 when idle.
REQ-012 Port busy  output  1  high in GRANT and RELEASE states.
REQ-013 Port timeout_pulse  output  1  one-cycle pulse on forced release.

Function
REQ-014 FSM states IDLE, GRANT, RELEASE; encoding from the shared package.
REQ-015 IDLE: if any unmasked req bit is high, select the winner round-robin, go to GRANT, and assert gnt[winner] on the next edge (1-cycle grant latency).
REQ-016 Round-robin: search starts at last owner+1, modulo NUM_REQ, wrapping past NUM_REQ-1 to 0; after reset the search starts at 0.
REQ-017 GRANT: gnt held while req[owner]=1; other req changes are ignored.
REQ-018 GRANT, req[owner] sampled 0: go to RELEASE; gnt and bus_valid are 0 from the next edge.
REQ-019 RELEASE lasts exactly one cycle, then IDLE; minimum idle gap between two grants is 2 cycles.
REQ-020 sharedBus/bus_valid: each cycle in GRANT with req[owner]=1, register wr_data[owner] and set bus_valid=1 on the next edge; otherwise bus_valid=0 and sharedBus holds its last value.
REQ-021 Simultaneous requests in IDLE: exactly one grant, per REQ-016; the losers stay pending with no loss.
REQ-022 A request that drops before it is granted is never granted.

Reset
REQ-023 With reset=1 at an edge: state IDLE, gnt=0, sharedBus=0, bus_valid=0, owner=0, busy=0, timeout_pulse=0, RR pointer=0, hold counter=0, mask=0.
REQ-024 Reset mid-grant drops gnt on that edge with no RELEASE cycle and no timeout_pulse.

Configuration
REQ-025 Macro ARB_TIMEOUT_EN, when defined, adds a hold counter that is cleared on grant and increments each GRANT cycle.
REQ-026 With ARB_TIMEOUT_EN, when the counter reaches MAX_HOLD: force RELEASE, pulse timeout_pulse for 1 cycle, and set mask[owner].
REQ-027 A masked requester is excluded from arbitration; its mask bit clears when its req is sampled 0.
REQ-028 Without ARB_TIMEOUT_EN: no counter and no mask, timeout_pulse tied 0, and grant length is unbounded.

Structure
REQ-029 Package handshake_arbiter_pkg holds the state enum typedef and the default parameter constants.
REQ-030 One sub-module, rr_picker, is combinational: inputs pending vector and start index; outputs winner index and a found flag.

Verification
REQ-031 req=4'b0010 held 5 cycles -> gnt=4'b0010 one cycle later, owner=1, bus_valid=1 for 5 cycles, sharedBus=wr_data[1].
REQ-032 req=4'b1111 held, each owner dropping after 3 cycles -> grant order 0,1,2,3,0, with a 2-cycle gap between grants.
REQ-033 Owner 3 drops; req=4'b1001 -> next grant to 0 (wrap-around).
REQ-034 ARB_TIMEOUT_EN, MAX_HOLD=16, req[2] held 40 cycles -> gnt[2] for 16 cycles, timeout_pulse once, no regrant until req[2] drops.
REQ-035 reset asserted mid-GRANT -> all outputs 0 on the next edge; after reset, req=4'b0110 -> grant to 1.
REQ-036 Check every cycle: gnt is one-hot or zero, and bus_valid=1 implies busy=1.
